// File: rtl/ctrl_pkg.sv
// Shared control-bundle widths, bit positions and opcode constants for the
// pipelined control path and anything that decodes into it.
package ctrl_pkg;

  localparam int EX_W  = 4;
  localparam int M_W   = 3;
  localparam int WB_W  = 2;
  localparam int REG_W = 5;

  // EX bundle bit positions
  localparam int EX_REGDST = 3;
  localparam int EX_ALUOP1 = 2;
  localparam int EX_ALUSRC = 1;
  localparam int EX_ALUOP0 = 0;

  // M bundle bit positions
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // WB bundle bit positions
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Opcodes seen by decode
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [M_W-1:0]   m;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] rt;
  } idex_t;

  typedef struct packed {
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } exmem_t;

  typedef logic [WB_W-1:0] memwb_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-to-control-pipe bundle: decode side drives the id_* fields and the
// branch resolution, the control pipe returns the decoded stage controls.
interface ctrl_pipe_if;
  import ctrl_pkg::*;

  logic [EX_W-1:0]  id_ex;
  logic [M_W-1:0]   id_m;
  logic [WB_W-1:0]  id_wb;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             branch_taken;

  logic       ex_regdst;
  logic       ex_alusrc;
  logic [1:0] ex_aluop;
  logic       mem_branch;
  logic       mem_memread;
  logic       mem_memwrite;
  logic       wb_regwrite;
  logic       wb_memtoreg;
  logic       hazard_stall;
  logic       pc_write;
  logic       ifid_write;

  modport master (
    output id_ex, id_m, id_wb, id_rs, id_rt, branch_taken,
    input  ex_regdst, ex_alusrc, ex_aluop, mem_branch, mem_memread,
           mem_memwrite, wb_regwrite, wb_memtoreg, hazard_stall,
           pc_write, ifid_write
  );

  modport slave (
    input  id_ex, id_m, id_wb, id_rs, id_rt, branch_taken,
    output ex_regdst, ex_alusrc, ex_aluop, mem_branch, mem_memread,
           mem_memwrite, wb_regwrite, wb_memtoreg, hazard_stall,
           pc_write, ifid_write
  );
endinterface

// File: rtl/ctrl_stage_reg.sv
// Width-parameterised pipeline stage register. Reset and bubble both force
// zero control so a squashed slot can never write memory or the register file.
module ctrl_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bubble_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Clear on reset or bubble, otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (rst || bubble_i) q_q <= '0;
    else if (en_i)       q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: carries decoded EX/M/WB bundles from ID through
// ID/EX, EX/MEM and MEM/WB, inserting bubbles for load-use stalls and
// squashing the two younger stages on a taken branch.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [EX_W-1:0]  id_ex,
  input  logic [M_W-1:0]   id_m,
  input  logic [WB_W-1:0]  id_wb,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             branch_taken,
  output logic             ex_regdst,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             mem_branch,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic             hazard_stall,
  output logic             pc_write,
  output logic             ifid_write
);

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  // A load in EX whose destination feeds the instruction in ID must hold ID
  // one cycle. A taken branch squashes that instruction anyway, so it masks
  // the stall and the flush alone takes effect.
  assign hazard_stall = idex_q.m[M_MEMREAD] && (idex_q.rt != '0) &&
                        ((idex_q.rt == id_rs) || (idex_q.rt == id_rt)) &&
                        !branch_taken;
  assign pc_write     = !hazard_stall;
  assign ifid_write   = !hazard_stall;

  assign idex_d  = '{ex: id_ex, m: id_m, wb: id_wb, rt: id_rt};
  assign exmem_d = '{m: idex_q.m, wb: idex_q.wb};
  assign memwb_d = exmem_q.wb;

  // ID/EX: bubble on stall or taken branch.
  ctrl_stage_reg #(.W($bits(idex_t))) u_idex (
    .clk(clk), .rst(rst), .bubble_i(hazard_stall || branch_taken),
    .en_i(1'b1), .d_i(idex_d), .q_o(idex_q)
  );

  // EX/MEM: the instruction behind a taken branch is squashed here too.
  ctrl_stage_reg #(.W($bits(exmem_t))) u_exmem (
    .clk(clk), .rst(rst), .bubble_i(branch_taken),
    .en_i(1'b1), .d_i(exmem_d), .q_o(exmem_q)
  );

  // MEM/WB: the branch itself always retires.
  ctrl_stage_reg #(.W($bits(memwb_t))) u_memwb (
    .clk(clk), .rst(rst), .bubble_i(1'b0),
    .en_i(1'b1), .d_i(memwb_d), .q_o(memwb_q)
  );

  assign ex_regdst    = idex_q.ex[EX_REGDST];
  assign ex_alusrc    = idex_q.ex[EX_ALUSRC];
  assign ex_aluop     = {idex_q.ex[EX_ALUOP1], idex_q.ex[EX_ALUOP0]};
  assign mem_branch   = exmem_q.m[M_BRANCH];
  assign mem_memread  = exmem_q.m[M_MEMREAD];
  assign mem_memwrite = exmem_q.m[M_MEMWRITE];
  assign wb_regwrite  = memwb_q[WB_REGWRITE];
  assign wb_memtoreg  = memwb_q[WB_MEMTOREG];

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed vector table covering the documented
// sequences, then random traffic against an instruction-slot model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if bus();

  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .id_ex(bus.id_ex), .id_m(bus.id_m), .id_wb(bus.id_wb),
    .id_rs(bus.id_rs), .id_rt(bus.id_rt), .branch_taken(bus.branch_taken),
    .ex_regdst(bus.ex_regdst), .ex_alusrc(bus.ex_alusrc), .ex_aluop(bus.ex_aluop),
    .mem_branch(bus.mem_branch), .mem_memread(bus.mem_memread),
    .mem_memwrite(bus.mem_memwrite), .wb_regwrite(bus.wb_regwrite),
    .wb_memtoreg(bus.wb_memtoreg), .hazard_stall(bus.hazard_stall),
    .pc_write(bus.pc_write), .ifid_write(bus.ifid_write)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // eex packs {regdst, aluop1, aluop0, alusrc}; em {branch, memread, memwrite}
  typedef struct {
    logic       r;
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rs, rt;
    logic       bt;
    logic       cs;
    logic       st;
    logic [3:0] eex;
    logic [2:0] em;
    logic [1:0] ew;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] ex, logic [2:0] m, logic [1:0] wb,
                              logic [4:0] rs, logic [4:0] rt, logic bt, logic cs,
                              logic st, logic [3:0] eex, logic [2:0] em, logic [1:0] ew);
    vec_t v;
    v.r = r; v.ex = ex; v.m = m; v.wb = wb; v.rs = rs; v.rt = rt; v.bt = bt;
    v.cs = cs; v.st = st; v.eex = eex; v.em = em; v.ew = ew;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [3:0] ex, input logic [2:0] m,
                       input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                       input logic bt);
    rst = r; bus.id_ex = ex; bus.id_m = m; bus.id_wb = wb;
    bus.id_rs = rs; bus.id_rt = rt; bus.branch_taken = bt;
  endtask

  task automatic chk_stall(input string nm, input logic st);
    chk({nm, ".stall"}, {7'd0, bus.hazard_stall}, {7'd0, st});
    chk({nm, ".pcw"},   {7'd0, bus.pc_write},     {7'd0, !st});
    chk({nm, ".ifidw"}, {7'd0, bus.ifid_write},   {7'd0, !st});
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] eex, input logic [2:0] em,
                          input logic [1:0] ew);
    chk({nm, ".ex"},  {4'd0, bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc}, {4'd0, eex});
    chk({nm, ".mem"}, {5'd0, bus.mem_branch, bus.mem_memread, bus.mem_memwrite}, {5'd0, em});
    chk({nm, ".wb"},  {6'd0, bus.wb_regwrite, bus.wb_memtoreg}, {6'd0, ew});
  endtask

  // Behavioural model: three slots holding whole instructions.
  typedef struct {
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rt;
  } ins_t;

  ins_t slot[3];
  localparam ins_t NOP_I = '{ex: 4'd0, m: 3'd0, wb: 2'd0, rt: 5'd0};

  vec_t tbl[30];

  initial begin
    // R=1100/000/10  LW=0010/010/11  SW=0010/001/00  BEQ=0001/100/00
    tbl[0]  = mk(1, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 2'b00);
    tbl[1]  = mk(0, 4'b1100, 3'b000, 2'b10, 1, 2, 0, 1, 0, 4'b1100, 3'b000, 2'b00);
    tbl[2]  = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b00);
    tbl[3]  = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b10);
    tbl[4]  = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b00);
    tbl[5]  = mk(0, 4'b0010, 3'b010, 2'b11, 0, 5, 0, 1, 0, 4'b0001, 3'b000, 2'b00);
    tbl[6]  = mk(0, 4'b1100, 3'b000, 2'b10, 5, 6, 0, 1, 1, 4'b0000, 3'b010, 2'b00);
    tbl[7]  = mk(0, 4'b1100, 3'b000, 2'b10, 5, 6, 0, 1, 0, 4'b1100, 3'b000, 2'b11);
    tbl[8]  = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b00);
    tbl[9]  = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b10);
    tbl[10] = mk(0, 4'b0010, 3'b010, 2'b11, 0, 0, 0, 1, 0, 4'b0001, 3'b000, 2'b00);
    tbl[11] = mk(0, 4'b1100, 3'b000, 2'b10, 0, 0, 0, 1, 0, 4'b1100, 3'b010, 2'b00);
    tbl[12] = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b11);
    tbl[13] = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b10);
    tbl[14] = mk(0, 4'b0001, 3'b100, 2'b00, 1, 2, 0, 1, 0, 4'b0010, 3'b000, 2'b00);
    tbl[15] = mk(0, 4'b0010, 3'b001, 2'b00, 3, 4, 0, 1, 0, 4'b0001, 3'b100, 2'b00);
    tbl[16] = mk(0, 4'b1100, 3'b000, 2'b10, 7, 8, 1, 1, 0, 4'b0000, 3'b000, 2'b00);
    tbl[17] = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b00);
    tbl[18] = mk(0, 4'b1100, 3'b000, 2'b10, 0, 0, 0, 1, 0, 4'b1100, 3'b000, 2'b00);
    tbl[19] = mk(0, 4'b0010, 3'b010, 2'b11, 0, 9, 0, 1, 0, 4'b0001, 3'b000, 2'b00);
    tbl[20] = mk(0, 4'b1100, 3'b000, 2'b10, 9, 1, 1, 1, 0, 4'b0000, 3'b000, 2'b10);
    tbl[21] = mk(0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 2'b00);
    tbl[22] = mk(0, 4'b0010, 3'b010, 2'b11, 0, 3, 0, 1, 0, 4'b0001, 3'b000, 2'b00);
    tbl[23] = mk(0, 4'b0010, 3'b001, 2'b00, 1, 3, 0, 1, 1, 4'b0000, 3'b010, 2'b00);
    tbl[24] = mk(0, 4'b0010, 3'b001, 2'b00, 1, 3, 0, 1, 0, 4'b0001, 3'b000, 2'b11);
    tbl[25] = mk(0, 4'b0010, 3'b001, 2'b00, 0, 0, 0, 1, 0, 4'b0001, 3'b001, 2'b00);
    tbl[26] = mk(0, 4'b1100, 3'b000, 2'b10, 0, 0, 0, 1, 0, 4'b1100, 3'b001, 2'b00);
    tbl[27] = mk(0, 4'b0010, 3'b010, 2'b11, 0, 2, 0, 1, 0, 4'b0001, 3'b000, 2'b00);
    tbl[28] = mk(1, 4'b1100, 3'b000, 2'b10, 2, 0, 0, 1, 1, 4'b0000, 3'b000, 2'b00);
    tbl[29] = mk(0, 4'b0000, 3'b000, 2'b00, 2, 2, 0, 1, 0, 4'b0000, 3'b000, 2'b00);

    drive(1, 0, 0, 0, 0, 0, 0);

    // Directed table: stall/pc_write checked before the edge, stage outputs after.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].ex, tbl[i].m, tbl[i].wb, tbl[i].rs, tbl[i].rt, tbl[i].bt);
      #1;
      if (tbl[i].cs) chk_stall($sformatf("vec%0d", i), tbl[i].st);
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].eex, tbl[i].em, tbl[i].ew);
    end

    // Random traffic: reset once, then compare against the slot model.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) slot[k] = NOP_I;
    chk_stall("rnd_reset", 1'b0);
    for (int n = 0; n < 400; n++) begin
      ins_t nw;
      logic r, bt, st;
      logic [4:0] rs;
      @(negedge clk);
      r  = ($urandom_range(0, 19) == 0);
      bt = ($urandom_range(0, 5) == 0);
      rs = 5'($urandom_range(0, 3));
      nw.ex = 4'($urandom_range(0, 15));
      nw.m  = 3'($urandom_range(0, 7));
      nw.wb = 2'($urandom_range(0, 3));
      nw.rt = 5'($urandom_range(0, 3));
      drive(r, nw.ex, nw.m, nw.wb, rs, nw.rt, bt);
      // A load in EX blocks a dependent ID instruction unless a branch squashes it.
      st = !bt && slot[0].m[1] && slot[0].rt != 0 &&
           (slot[0].rt == rs || slot[0].rt == nw.rt);
      #1;
      chk_stall($sformatf("rnd%0d", n), st);
      if (r) begin
        for (int k = 0; k < 3; k++) slot[k] = NOP_I;
      end else begin
        slot[2] = slot[1];
        slot[1] = bt ? NOP_I : slot[0];
        slot[0] = (bt || st) ? NOP_I : nw;
      end
      @(posedge clk);
      #1;
      chk_outs($sformatf("rnd%0d", n),
               {slot[0].ex[3], slot[0].ex[2], slot[0].ex[0], slot[0].ex[1]},
               slot[1].m, slot[2].wb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
